// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter: round-robin front end that shares one BankController
// between NUM_REQ requesters. One transaction (single read or write) is in
// flight at a time. Flow: accept -> one-cycle command pulse -> wait for
// ack or timeout -> one-cycle response pulse back to the owner.
module bank_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ROW_W-1:0]  req_row,
    input  logic [NUM_REQ*COL_W-1:0]  req_col,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_err,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      bank_read_en,
    output logic                      bank_write_en,
    output logic [ROW_W-1:0]          bank_row,
    output logic [COL_W-1:0]          bank_col,
    output logic [DATA_W-1:0]         bank_wdata,
    input  logic [DATA_W-1:0]         bank_rdata,
    input  logic                      bank_ack,
    input  logic                      bank_busy,
    output logic                      arb_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W:0]   NREQ     = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic               lat_we;
    logic [CNT_W-1:0]   cnt;

    // Per-requester views of the flattened buses (element i = bits [i*W +: W]).
    logic [NUM_REQ-1:0][ROW_W-1:0]  row_a;
    logic [NUM_REQ-1:0][COL_W-1:0]  col_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

    assign row_a   = req_row;
    assign col_a   = req_col;
    assign wdata_a = req_wdata;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     scan;
    logic               take;
    logic [NUM_REQ-1:0] owner_oh;

    // Round-robin pick: first valid at or after ptr, wrapping. Scan runs from
    // the far end back toward ptr so the closest hit is the one that sticks.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + (IDX_W+1)'(k);
            if (scan >= NREQ) scan = scan - NREQ;
            if (req_valid[scan[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[IDX_W-1:0];
            end
        end
    end

    // A request is taken only in IDLE with the controller free; gated by reset
    // so nothing looks accepted while the block is being cleared.
    assign take     = (state == ST_IDLE) && grant_vld && !bank_busy && !reset;
    assign owner_oh = NUM_REQ'(1) << owner;
    assign arb_busy = (state != ST_IDLE);

    // Accept pulse is combinational so the requester sees it in the grant cycle.
    always_comb begin
        req_accept = '0;
        if (take) req_accept[grant_idx] = 1'b1;
    end

    // Transaction FSM; command pulses and response pulses are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            lat_we        <= 1'b0;
            cnt           <= '0;
            resp_valid    <= '0;
            resp_err      <= 1'b0;
            resp_data     <= '0;
            bank_read_en  <= 1'b0;
            bank_write_en <= 1'b0;
            bank_row      <= '0;
            bank_col      <= '0;
            bank_wdata    <= '0;
        end else begin
            bank_read_en  <= 1'b0;
            bank_write_en <= 1'b0;
            resp_valid    <= '0;
            resp_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner         <= grant_idx;
                        lat_we        <= req_we[grant_idx];
                        bank_row      <= row_a[grant_idx];
                        bank_col      <= col_a[grant_idx];
                        bank_wdata    <= wdata_a[grant_idx];
                        bank_write_en <= req_we[grant_idx];
                        bank_read_en  <= !req_we[grant_idx];
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bank_ack) begin
                        if (!lat_we) resp_data <= bank_rdata;
                        resp_valid <= owner_oh;
                        state      <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= owner_oh;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
